vendor_mem_hard_macro: RTL and testbench

Flop-based two-port register-file macro: one synchronous word-write port and one asynchronous (combinational) read port, both on a single clock domain. It is the storage array behind the NoC link FIFO buffers. It stands in for the 8-word x 61-bit `tpRam_*_awn_raws` memory class, and is parameterised for other depth/width pairs. Reset clears the array. No consumer relies on the cleared contents.

---
 rtl/vendor_mem_pkg.sv | 12 +
 rtl/vendor_mem_row.sv | 21 ++
 rtl/vendor_mem_hard_macro.sv | 64 ++++++
 tb/tb_vendor_mem_hard_macro.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vendor_mem_pkg.sv
// Shared types and defaults for the flop-based register-file macro.
// Default geometry matches the 8 x 61 NoC link FIFO storage.
package vendor_mem_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 61;

  typedef logic [WIDTH_DEF-1:0] mem_word_t;

  localparam mem_word_t RDATA_IDLE = '1;

endpackage

// File: rtl/vendor_mem_row.sv
// One storage word of the register-file macro.
// Reset wins over a coincident write.
module vendor_mem_row #(
  parameter int WIDTH = 61
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vendor_mem_hard_macro.sv
// Two-port flop register file: synchronous word write, combinational read.
// Idle or out-of-range reads return all-ones.
module vendor_mem_hard_macro
  import vendor_mem_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [AW:0]      DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] IDLE    = '1;

  logic [WIDTH-1:0] q [DEPTH];
  logic [DEPTH-1:0] we;

  // Only rows below DEPTH exist, so an out-of-range waddr decodes to nothing.
  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i] = wen && (waddr == AW'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    vendor_mem_row #(
      .WIDTH (WIDTH)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .we  (we[g]),
      .d   (wdata),
      .q   (q[g])
    );
  end

  always_comb begin
    rdata = IDLE;
    if (ren && ({1'b0, raddr} < DEPTH_W)) begin
      rdata = q[raddr];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && wen) begin
      assert (!$isunknown(waddr))
        else $warning("Z or X in address on write at %0t", $time);
      assert ({1'b0, waddr} < DEPTH_W)
        else $warning("Address out of range on write at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_vendor_mem_hard_macro.sv
// Directed bench for the register-file macro, default and 6 x 8 geometry.
// Expected values are hand-computed constants.
module tb_vendor_mem_hard_macro;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [2:0]  waddr;
  logic [60:0] wdata;
  logic        ren;
  logic [2:0]  raddr;
  logic [60:0] rdata;

  logic        s_rst;
  logic        s_wen;
  logic [2:0]  s_waddr;
  logic [7:0]  s_wdata;
  logic        s_ren;
  logic [2:0]  s_raddr;
  logic [7:0]  s_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [60:0] BASE = 61'h0AAA_0000_0000_0000;
  localparam logic [60:0] ONES = 61'h1FFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  vendor_mem_hard_macro u_dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata)
  );

  vendor_mem_hard_macro #(
    .DEPTH (6),
    .WIDTH (8)
  ) u_small (
    .clk   (clk),
    .rst   (s_rst),
    .wen   (s_wen),
    .waddr (s_waddr),
    .wdata (s_wdata),
    .ren   (s_ren),
    .raddr (s_raddr),
    .rdata (s_rdata)
  );

  task automatic check(input string tag,
                       input logic [60:0] obs,
                       input logic [60:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [60:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [2:0] a,
                    input logic [60:0] exp);
    ren   = 1'b1;
    raddr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    ren = 1'b0; raddr = '0;
    s_rst = 1'b1; s_wen = 1'b0; s_waddr = '0; s_wdata = '0;
    s_ren = 1'b0; s_raddr = '0;
    tick();
    rst = 1'b0;
    s_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rd($sformatf("reset_rd%0d", i), 3'(i), 61'h0);
    end
    ren = 1'b0;
    #1;
    check("idle_ones", rdata, ONES);

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), BASE + 61'(i));
    end
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("fill_rd%0d", i), 3'(i), BASE + 61'(i));
    end

    wr(3'd3, 61'h5);
    rd("rw_pre_old", 3'd3, 61'h5);
    wen = 1'b1; waddr = 3'd3; wdata = 61'h1234;
    #1;
    check("rw_before_edge", rdata, 61'h5);
    tick();
    wen = 1'b0;
    check("rw_after_edge", rdata, 61'h1234);
    rd("rw_other2", 3'd2, BASE + 61'd2);
    rd("rw_other4", 3'd4, BASE + 61'd4);

    rst = 1'b1; wen = 1'b1; waddr = 3'd2; wdata = 61'hFF;
    tick();
    rst = 1'b0; wen = 1'b0;
    rd("rst_prio2", 3'd2, 61'h0);
    rd("rst_clear5", 3'd5, 61'h0);

    wr(3'd6, 61'h77);
    rd("mid_wr77", 3'd6, 61'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd("mid_rst6", 3'd6, 61'h0);
    wr(3'd6, 61'h99);
    rd("mid_wr99", 3'd6, 61'h99);

    s_wen = 1'b1; s_waddr = 3'd0; s_wdata = 8'hA5;
    tick();
    s_waddr = 3'd7; s_wdata = 8'h3C;
    tick();
    s_wen = 1'b0;
    s_ren = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_raddr = 3'(i);
      #1;
      check($sformatf("small_rd%0d", i), 61'(s_rdata),
            (i == 0) ? 61'hA5 : 61'h0);
    end
    s_raddr = 3'd7;
    #1;
    check("small_oor7", 61'(s_rdata), 61'hFF);
    s_raddr = 3'd6;
    #1;
    check("small_oor6", 61'(s_rdata), 61'hFF);
    s_ren = 1'b0;
    s_raddr = 3'd0;
    #1;
    check("small_idle", 61'(s_rdata), 61'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
